// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

   localparam int MULDIV_WIDTH = 32;
   // One shift-add or shift-subtract iteration per operand bit.
   localparam int MULDIV_ITERS = MULDIV_WIDTH;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   typedef enum logic {
      STEP_MUL = 1'b0,
      STEP_DIV = 1'b1
   } step_mode_t;

   // MULT and DIV treat their operands as two's-complement numbers.
   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned multiply/divide datapath.
// Multiply: acc = {partial_product, remaining_multiplier}; add the
// multiplicand on the multiplier LSB, then shift right.
// Divide: acc = {partial_remainder, remaining_dividend}; restoring
// shift-subtract. The quotient bit is returned separately and the
// accumulator LSB is left clear for the caller to fill.
module muldiv_step
   import mips_muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
)
(
   input  step_mode_t           i_mode,
   input  logic [2*WIDTH-1:0]   i_acc,
   input  logic [WIDTH-1:0]     i_operand,
   output logic [2*WIDTH-1:0]   o_acc,
   output logic                 o_qbit
);

   logic [WIDTH:0] w_mul_sum;
   logic [WIDTH:0] w_trial;

   // Compute both candidate updates and select by mode.
   always_comb begin
      w_mul_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                + (i_acc[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});
      w_trial   = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_operand};
      o_acc     = '0;
      o_qbit    = 1'b0;
      if (i_mode == STEP_MUL) begin
         o_acc = {w_mul_sum, i_acc[WIDTH-1:1]};
      end else begin
         // Non-negative trial difference means the divisor fits.
         o_qbit = ~w_trial[WIDTH];
         if (o_qbit) begin
            o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
         end else begin
            o_acc = {i_acc[2*WIDTH-2:WIDTH-1], i_acc[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are latched as magnitudes plus sign flags, WIDTH iterations run
// in RUN, and FIX applies sign correction and writes HI/LO in one cycle.
module hilo_muldiv
   import mips_muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output state_t           o_dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t               r_state;
   state_t               w_next_state;
   logic                 w_load;
   logic                 w_iter;
   logic                 w_fix;
   logic                 w_mt;

   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_operand;
   logic [WIDTH-1:0]     r_rs_raw;
   logic [CW-1:0]        r_cnt;
   logic                 r_is_mul;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic                 r_div_zero;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_done;

   logic                 w_op_long;
   logic                 w_op_mt;
   logic                 w_signed;
   logic                 w_is_mul;
   logic                 w_sa;
   logic                 w_sb;
   logic [WIDTH-1:0]     w_abs_a;
   logic [WIDTH-1:0]     w_abs_b;
   step_mode_t           w_mode;
   logic [2*WIDTH-1:0]   w_step_acc;
   logic                 w_qbit;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quo;
   logic [WIDTH-1:0]     w_rem;
   logic [WIDTH-1:0]     w_res_hi;
   logic [WIDTH-1:0]     w_res_lo;

   // Operand decode; abs of the most negative value wraps to itself and is
   // then read as an unsigned magnitude.
   assign w_op_long = (op == OP_MULT) || (op == OP_MULTU) ||
                      (op == OP_DIV)  || (op == OP_DIVU);
   assign w_op_mt   = (op == OP_MTHI) || (op == OP_MTLO);
   assign w_signed  = op_is_signed(op);
   assign w_is_mul  = (op == OP_MULT) || (op == OP_MULTU);
   assign w_sa      = w_signed & rs_val[WIDTH-1];
   assign w_sb      = w_signed & rt_val[WIDTH-1];
   assign w_abs_a   = w_sa ? -rs_val : rs_val;
   assign w_abs_b   = w_sb ? -rt_val : rt_val;
   assign w_mode    = r_is_mul ? STEP_MUL : STEP_DIV;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_mode    (w_mode),
      .i_acc     (r_acc),
      .i_operand (r_operand),
      .o_acc     (w_step_acc),
      .o_qbit    (w_qbit)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // FSM next state and per-cycle action strobes.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_iter       = 1'b0;
      w_fix        = 1'b0;
      w_mt         = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && w_op_long) begin
               w_load       = 1'b1;
               w_next_state = RUN;
            end else if (start && w_op_mt) begin
               w_mt = 1'b1;
            end
         end
         RUN: begin
            w_iter = 1'b1;
            if (r_cnt == LAST_CNT) w_next_state = FIX;
         end
         FIX: begin
            w_fix        = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Operand latch and iteration datapath. The accumulator upper half is
   // cleared at load; the lower half holds the operand shifted out bitwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc      <= '0;
         r_operand  <= '0;
         r_rs_raw   <= '0;
         r_cnt      <= '0;
         r_is_mul   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
      end else if (w_load) begin
         r_acc      <= {{WIDTH{1'b0}}, (w_is_mul ? w_abs_b : w_abs_a)};
         r_operand  <= w_is_mul ? w_abs_a : w_abs_b;
         r_rs_raw   <= rs_val;
         r_cnt      <= '0;
         r_is_mul   <= w_is_mul;
         r_neg_q    <= w_sa ^ w_sb;
         r_neg_r    <= w_sa & ~w_is_mul;
         r_div_zero <= ~w_is_mul && (rt_val == '0);
      end else if (w_iter) begin
         r_acc <= w_step_acc | {{(2*WIDTH-1){1'b0}}, w_qbit};
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Sign fix-up and final result selection, consumed in FIX.
   always_comb begin
      w_prod   = r_neg_q ? -r_acc : r_acc;
      w_quo    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      w_res_hi = w_rem;
      w_res_lo = w_quo;
      if (r_is_mul) begin
         w_res_hi = w_prod[2*WIDTH-1:WIDTH];
         w_res_lo = w_prod[WIDTH-1:0];
      end else if (r_div_zero) begin
         // Deterministic divide-by-zero result regardless of signedness.
         w_res_hi = r_rs_raw;
         w_res_lo = '1;
      end
   end

   // HI/LO architectural registers and the one-cycle done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_fix | w_mt;
         if (w_fix) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end else if (w_mt) begin
            if (op == OP_MTHI) r_hi <= rs_val;
            else               r_lo <= rs_val;
         end
      end
   end

   assign busy        = (r_state != IDLE);
   assign done        = r_done;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: hand-computed HI/LO results, latency,
// busy length, ignored starts, MTHI/MTLO and reset abort.
module tb_hilo_muldiv;
   import mips_muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] rs_val;
   logic [W-1:0] rt_val;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   state_t       dbg_state;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] exp_q[$];

   int           c_done;
   int           n_busy;
   int           n_done;

   hilo_muldiv #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .o_dbg_state (dbg_state)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Present a one-cycle start at the current negedge; returns one cycle later.
   task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Cycle 1 is the cycle after the start edge; stops in the done cycle.
   task automatic wait_done(input string tag, output int cyc, output int nb);
      cyc = 0;
      nb  = 0;
      for (int c = 1; c <= 60; c++) begin
         if (busy) nb++;
         if (done && busy) check_eq({tag, "_done_busy"}, 32'(busy), 32'(0));
         if (done) begin
            cyc = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
      int cyc;
      int nb;
      drive(o, a, b);
      // Operands must have been latched; scramble the inputs.
      rs_val = $urandom;
      rt_val = $urandom;
      exp_q.push_back(eh);
      exp_q.push_back(el);
      wait_done(tag, cyc, nb);
      check_eq({tag, "_lat"}, 32'(cyc), 32'(34));
      check_eq({tag, "_busy"}, 32'(nb), 32'(33));
      check_eq({tag, "_hi"}, hi, exp_q.pop_front());
      check_eq({tag, "_lo"}, lo, exp_q.pop_front());
   endtask

   initial begin
      // Reset
      reset  = 1'b1;
      start  = 1'b0;
      op     = 3'd0;
      rs_val = '0;
      rt_val = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_eq("rst_hi", hi, 32'h0);
      check_eq("rst_lo", lo, 32'h0);
      check_eq("rst_busy", 32'(busy), 32'(0));
      check_eq("rst_done", 32'(done), 32'(0));
      check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);

      // Arithmetic vectors
      run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_op("mult_m3x5", OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
      run_op("mult_min2", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      run_op("div_m7_2",  OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_7_m2",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      run_op("divu_100_7", OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14);
      run_op("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF);
      run_op("div_5_0",   OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
      run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);

      // Reserved opcode in the done cycle: nothing changes.
      drive(3'd6, 32'h55, 32'h66);
      check_eq("op6_done", 32'(done), 32'(0));
      check_eq("op6_busy", 32'(busy), 32'(0));
      check_eq("op6_hi", hi, 32'h0);
      check_eq("op6_lo", lo, 32'h80000000);

      // MTHI then MTLO on back-to-back cycles
      start  = 1'b1;
      op     = OP_MTHI;
      rs_val = 32'h12345678;
      @(negedge clk);
      op     = OP_MTLO;
      rs_val = 32'hCAFEBABE;
      check_eq("mthi_done", 32'(done), 32'(1));
      check_eq("mthi_busy", 32'(busy), 32'(0));
      check_eq("mthi_hi", hi, 32'h12345678);
      check_eq("mthi_lo", lo, 32'h80000000);
      @(negedge clk);
      start = 1'b0;
      check_eq("mtlo_done", 32'(done), 32'(1));
      check_eq("mtlo_busy", 32'(busy), 32'(0));
      check_eq("mtlo_hi", hi, 32'h12345678);
      check_eq("mtlo_lo", lo, 32'hCAFEBABE);
      @(negedge clk);
      check_eq("mt_done_clr", 32'(done), 32'(0));

      // Start while busy is dropped
      drive(OP_DIVU, 32'd100, 32'd7);
      n_done = 0;
      c_done = 0;
      for (int c = 1; c <= 34; c++) begin
         start = (c == 10);
         if (c == 10) begin
            op     = OP_MULTU;
            rs_val = 32'd2;
            rt_val = 32'd3;
         end
         if (done) begin
            n_done++;
            c_done = c;
         end
         if (c < 34) @(negedge clk);
      end
      start = 1'b0;
      check_eq("drop_ndone", 32'(n_done), 32'(1));
      check_eq("drop_lat", 32'(c_done), 32'(34));
      check_eq("drop_hi", hi, 32'd2);
      check_eq("drop_lo", lo, 32'd14);
      // Start accepted in the done cycle
      run_op("multu_b2b", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

      // Reset mid-operation
      drive(OP_MTHI, 32'h0000AAAA, 32'h0);
      check_eq("ab_mthi_hi", hi, 32'h0000AAAA);
      drive(OP_MULT, 32'd5, 32'd7);
      repeat (18) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("ab_hi", hi, 32'h0);
      check_eq("ab_lo", lo, 32'h0);
      check_eq("ab_busy", 32'(busy), 32'(0));
      check_eq("ab_done", 32'(done), 32'(0));
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) n_done++;
         @(negedge clk);
      end
      check_eq("ab_nodone", 32'(n_done), 32'(0));
      run_op("divu_9_4", OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2);

      // Final report
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
